// File: rtl/spi_master_if.sv
// SPI master bundle: request/response handshake plus the SPI pins.
// The engine connects through the master modport, the stimulus/slave side through slave.
interface spi_master_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) ();
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic [CS_W-1:0]   req_cs_idx;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic [NUM_CS-1:0] cs_n;
  logic              sck;
  logic              mosi;
  logic              miso;

  modport master (
    input  req_valid, req_data, req_cs_idx, miso,
    output req_ready, rsp_valid, rsp_data, busy, cs_n, sck, mosi
  );

  modport slave (
    output req_valid, req_data, req_cs_idx, miso,
    input  req_ready, rsp_valid, rsp_data, busy, cs_n, sck, mosi
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master engine: one accepted request word becomes one full SPI frame
// (setup, 2*DATA_W SCK half-periods, hold) and the received word is returned
// with a single-cycle rsp_valid pulse. All four CPOL/CPHA modes, MSB/LSB first.
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_cpol,
  input  logic             cfg_cpha,
  input  logic             cfg_lsb_first,
  input  logic [DIV_W-1:0] cfg_div,
  spi_master_if.master     bus
);

  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int EDGES = 2 * DATA_W;
  localparam int EC_W  = $clog2(EDGES + 1);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [EC_W-1:0]  LAST_EDGE = EC_W'(EDGES - 1);
  localparam logic [BIT_W-1:0] MSB_IDX   = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD} state_t;

  state_t            state_reg;
  logic [DIV_W-1:0]  div_reg;
  logic              cpha_reg;
  logic              lsb_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [EC_W-1:0]   edge_cnt_reg;
  logic [NUM_CS-1:0] cs_n_reg;
  logic              sck_reg;
  logic              mosi_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              busy_reg;
  logic              ready_reg;

  logic              hp_end;
  logic              edge_odd;
  logic [BIT_W-1:0]  half_idx;
  logic [BIT_W-1:0]  shift_m;
  logic              shift_en;
  logic              sample_en;
  logic [BIT_W-1:0]  shift_idx;
  logic [BIT_W-1:0]  sample_idx;
  logic              first_bit;
  logic [NUM_CS-1:0] cs_sel_n;

  // Chip-select decode of the incoming request; an out-of-range index selects nobody.
  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
    assign cs_sel_n[gi] = (bus.req_cs_idx != CS_W'(gi));
  end

  // Edge bookkeeping: the upcoming SCK edge is number edge_cnt_reg+1, so an even
  // count means an odd edge. Bit m is shifted/sampled on edge 2m+1 or 2m+2.
  always_comb begin
    hp_end    = (div_cnt_reg == div_reg);
    edge_odd  = ~edge_cnt_reg[0];
    half_idx  = edge_cnt_reg[BIT_W:1];
    shift_m   = half_idx;
    shift_en  = 1'b0;
    sample_en = 1'b0;
    if (cpha_reg) begin
      shift_en  = edge_odd;
      sample_en = ~edge_odd;
    end else begin
      // Bit 0 already left during SETUP; the final (even) edge has nothing to shift.
      shift_m   = half_idx + 1'b1;
      shift_en  = ~edge_odd && (edge_cnt_reg != LAST_EDGE);
      sample_en = edge_odd;
    end
    shift_idx  = lsb_reg ? shift_m  : (MSB_IDX - shift_m);
    sample_idx = lsb_reg ? half_idx : (MSB_IDX - half_idx);
    first_bit  = cfg_lsb_first ? bus.req_data[0] : bus.req_data[DATA_W-1];
  end

  // Frame sequencer with all pin and handshake outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      div_reg       <= '0;
      cpha_reg      <= 1'b0;
      lsb_reg       <= 1'b0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      div_cnt_reg   <= '0;
      edge_cnt_reg  <= '0;
      cs_n_reg      <= '1;
      sck_reg       <= 1'b0;
      mosi_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      busy_reg      <= 1'b0;
      ready_reg     <= 1'b1;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          sck_reg <= cfg_cpol;
          if (bus.req_valid) begin
            div_reg      <= cfg_div;
            cpha_reg     <= cfg_cpha;
            lsb_reg      <= cfg_lsb_first;
            tx_reg       <= bus.req_data;
            rx_reg       <= '0;
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            cs_n_reg     <= cs_sel_n;
            if (!cfg_cpha) begin
              mosi_reg <= first_bit;
            end
            busy_reg  <= 1'b1;
            ready_reg <= 1'b0;
            state_reg <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (hp_end) begin
            div_cnt_reg <= '0;
            state_reg   <= ST_XFER;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        ST_XFER: begin
          if (hp_end) begin
            div_cnt_reg  <= '0;
            sck_reg      <= ~sck_reg;
            edge_cnt_reg <= edge_cnt_reg + 1'b1;
            if (shift_en) begin
              mosi_reg <= tx_reg[shift_idx];
            end
            if (sample_en) begin
              rx_reg[sample_idx] <= bus.miso;
            end
            if (edge_cnt_reg == LAST_EDGE) begin
              state_reg <= ST_HOLD;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        ST_HOLD: begin
          // SCK is already back at CPOL after an even number of toggles.
          if (hp_end) begin
            div_cnt_reg   <= '0;
            cs_n_reg      <= '1;
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= rx_reg;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b1;
            state_reg     <= ST_IDLE;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.busy      = busy_reg;
  assign bus.cs_n      = cs_n_reg;
  assign bus.sck       = sck_reg;
  assign bus.mosi      = mosi_reg;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a behavioural SPI slave reacting to sck/cs_n edges,
// directed frames for each mode plus randomized frames, each checked for
// latency, chip-select pattern, SCK edge count/period and data in both directions.
module tb_spi_master_ctrl;
  localparam int DW    = 8;
  localparam int NCS   = 3;
  localparam int DIV_W = 8;
  localparam int CS_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_cpol = 1'b0;
  logic             cfg_cpha = 1'b0;
  logic             cfg_lsb_first = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_if #(.DATA_W(DW), .NUM_CS(NCS), .CS_W(CS_W)) bus ();

  spi_master_ctrl #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_cpol     (cfg_cpol),
    .cfg_cpha     (cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first),
    .cfg_div      (cfg_div),
    .bus          (bus)
  );

  // Behavioural slave: mode settings, word to return, and what it captured.
  logic          m_cpol = 1'b0;
  logic          m_cpha = 1'b0;
  logic          m_lsb  = 1'b0;
  logic [DW-1:0] sl_word = '0;
  logic [DW-1:0] sl_cap  = '0;
  logic          sl_first = 1'b0;
  logic          sl_miso  = 1'b0;
  int            sl_tx_n = 0;
  int            sl_rx_n = 0;
  int            sl_edges = 0;
  int            hi_edges = 0;
  logic          sl_cs_prev = 1'b1;
  logic          sl_sck_prev = 1'b0;
  bit            loop_en = 1'b0;

  wire cs_idle = &bus.cs_n;

  // Unselected bus reads as 0; loopback ties miso straight to mosi.
  assign bus.miso = loop_en ? bus.mosi : (cs_idle ? 1'b0 : sl_miso);

  function automatic logic bit_of(input logic [DW-1:0] w, input int n, input logic lsb);
    return lsb ? w[n] : w[DW-1-n];
  endfunction

  always @(cs_idle or bus.sck) begin
    if (sl_cs_prev && !cs_idle) begin
      sl_edges = 0;
      sl_rx_n  = 0;
      sl_cap   = '0;
      if (!m_cpha) begin
        sl_miso = bit_of(sl_word, 0, m_lsb);
        sl_tx_n = 1;
      end else begin
        sl_miso = 1'b0;
        sl_tx_n = 0;
      end
    end else if (!cs_idle && bus.sck !== sl_sck_prev) begin
      sl_edges++;
      if ((bus.sck != m_cpol) ^ m_cpha) begin
        if (sl_rx_n < DW) begin
          if (sl_rx_n == 0) sl_first = bus.mosi;
          if (m_lsb) sl_cap[sl_rx_n] = bus.mosi;
          else       sl_cap[DW-1-sl_rx_n] = bus.mosi;
          sl_rx_n++;
        end
      end else if (sl_tx_n < DW) begin
        sl_miso = bit_of(sl_word, sl_tx_n, m_lsb);
        sl_tx_n++;
      end
    end else if (cs_idle && bus.sck !== sl_sck_prev) begin
      hi_edges++;
    end
    sl_cs_prev  = cs_idle;
    sl_sck_prev = bus.sck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic lsb, input int div);
    @(negedge clk);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb; cfg_div = DIV_W'(div);
    m_cpol = cpol; m_cpha = cpha; m_lsb = lsb;
    repeat (3) @(negedge clk);
  endtask

  // One frame: request, watch pins until the response, compare with the frame rules.
  task automatic run_frame(input logic [DW-1:0] data, input logic [CS_W-1:0] idx, input int h,
                           input logic [DW-1:0] exp_rsp, input bit twiddle, input string tag);
    int n, lat, cs_low, rises, first_rise, last_rise, wait_n, frame_len;
    logic sck_prev;
    logic [NCS-1:0] cs_seen, exp_cs;
    bit active;
    active = (int'(idx) < NCS);
    exp_cs = '1;
    for (int i = 0; i < NCS; i++) if (i == int'(idx)) exp_cs[i] = 1'b0;
    frame_len = (2 * DW + 2) * h;

    @(negedge clk);
    bus.req_data = data; bus.req_cs_idx = idx; bus.req_valid = 1'b1;
    wait_n = 0;
    while (bus.req_ready !== 1'b1 && wait_n < 200) begin
      @(negedge clk); wait_n++;
    end
    check({tag, " ready"}, 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({tag, " busy"}, 32'(bus.busy), 1);
    n = 0; lat = -1; cs_low = 0; rises = 0; first_rise = -1; last_rise = -1;
    sck_prev = bus.sck; cs_seen = '1;
    while (n < 2000) begin
      if (twiddle && n == 2) begin
        cfg_cpol = ~cfg_cpol;
        cfg_div  = cfg_div + 8'd4;
      end
      if (bus.rsp_valid === 1'b1) begin
        lat = n;
        break;
      end
      if (bus.cs_n !== '1) begin
        cs_low++;
        cs_seen = bus.cs_n;
      end
      if (sck_prev === 1'b0 && bus.sck === 1'b1) begin
        rises++;
        if (first_rise < 0) first_rise = n;
        last_rise = n;
      end
      sck_prev = bus.sck;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, lat, frame_len);
    check({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(exp_rsp));
    check({tag, " cs_low_cycles"}, cs_low, active ? frame_len : 0);
    check({tag, " cs_n"}, 32'(cs_seen), 32'(exp_cs));
    check({tag, " sck_rises"}, rises, DW);
    check({tag, " sck_period"}, last_rise - first_rise, (DW - 1) * 2 * h);
    if (active) begin
      check({tag, " slave_rx"}, 32'(sl_cap), 32'(data));
      check({tag, " first_mosi"}, 32'(sl_first), 32'(m_lsb ? data[0] : data[DW-1]));
    end
    @(negedge clk);
    check({tag, " rsp_pulse"}, 32'(bus.rsp_valid), 0);
    check({tag, " cs_release"}, 32'(bus.cs_n), 32'((1 << NCS) - 1));
    $display("frame %s data=%02h idx=%0d h=%0d lat=%0d rsp=%02h", tag, data, idx, h, lat, bus.rsp_data);
  endtask

  initial begin
    logic [DW-1:0] d1, d2, rsp1, rsp2;
    logic [CS_W-1:0] ridx;
    int n, pulses, n1, n2, hi0, wait_n;

    bus.req_valid = 1'b0; bus.req_data = '0; bus.req_cs_idx = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst cs_n", 32'(bus.cs_n), 32'((1 << NCS) - 1));
    check("rst sck", 32'(bus.sck), 0);
    check("rst mosi", 32'(bus.mosi), 0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst rsp_data", 32'(bus.rsp_data), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst ready", 32'(bus.req_ready), 1);
    rst_n = 1'b1;

    // Mode 0, fastest divider, loopback.
    set_mode(1'b0, 1'b0, 1'b0, 0);
    loop_en = 1'b1;
    run_frame(8'hA5, 2'd0, 1, 8'hA5, 1'b0, "mode0_loop");
    loop_en = 1'b0;

    // Mode 3, LSB first, H=4, slave returns 0x3C.
    set_mode(1'b1, 1'b1, 1'b1, 3);
    check("mode3 sck_idle", 32'(bus.sck), 1);
    sl_word = 8'h3C;
    run_frame(8'($urandom), 2'd0, 4, 8'h3C, 1'b0, "mode3_lsb");

    // Chip select decode, then out-of-range index.
    set_mode(1'b0, 1'b1, 1'b0, 1);
    sl_word = 8'($urandom);
    run_frame(8'($urandom), 2'd2, 2, sl_word, 1'b0, "cs_idx2");
    run_frame(8'($urandom), 2'd3, 2, 8'h00, 1'b0, "cs_none");

    // Back-to-back requests, valid held through the response cycle.
    set_mode(1'b1, 1'b0, 1'b0, 1);
    sl_word = 8'($urandom);
    d1 = 8'($urandom); d2 = 8'($urandom);
    hi0 = hi_edges;
    @(negedge clk);
    bus.req_data = d1; bus.req_cs_idx = 2'd1; bus.req_valid = 1'b1;
    wait_n = 0;
    while (bus.req_ready !== 1'b1 && wait_n < 200) begin
      @(negedge clk); wait_n++;
    end
    @(negedge clk);
    bus.req_data = d2;
    pulses = 0; n1 = -1; n2 = -1; rsp1 = '0; rsp2 = '0;
    for (n = 0; n < 200; n++) begin
      if (pulses == 1 && n == n1 + 1) bus.req_valid = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          n1 = n; rsp1 = bus.rsp_data;
          check("b2b ready_with_rsp", 32'(bus.req_ready), 1);
        end else if (pulses == 2) begin
          n2 = n; rsp2 = bus.rsp_data;
        end
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b pulses", pulses, 2);
    check("b2b rsp1", 32'(rsp1), 32'(sl_word));
    check("b2b rsp2", 32'(rsp2), 32'(sl_word));
    check("b2b gap", n2 - n1, (2 * DW + 2) * 2 + 1);
    check("b2b sck_while_cs_high", hi_edges - hi0, 0);
    check("b2b slave_rx2", 32'(sl_cap), 32'(d2));
    $display("b2b d1=%02h d2=%02h rsp1=%02h rsp2=%02h gap=%0d", d1, d2, rsp1, rsp2, n2 - n1);

    // Reset in the middle of a frame.
    set_mode(1'b0, 1'b1, 1'b0, 3);
    @(negedge clk);
    bus.req_data = 8'($urandom); bus.req_cs_idx = 2'd0; bus.req_valid = 1'b1;
    wait_n = 0;
    while (bus.req_ready !== 1'b1 && wait_n < 200) begin
      @(negedge clk); wait_n++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_n = 0;
    while (sl_edges < 5 && wait_n < 500) begin
      @(negedge clk); wait_n++;
    end
    check("rstmid reached_edge5", 32'(sl_edges), 5);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid cs_n", 32'(bus.cs_n), 32'((1 << NCS) - 1));
    check("rstmid sck", 32'(bus.sck), 0);
    check("rstmid mosi", 32'(bus.mosi), 0);
    check("rstmid busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    pulses = 0;
    for (n = 0; n < 80; n++) begin
      if (bus.rsp_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    check("rstmid no_rsp", pulses, 0);
    $display("reset_mid_frame rsp_pulses=%0d", pulses);

    // Config changed mid-frame; the new values apply to the next frame only.
    set_mode(1'b0, 1'b0, 1'b0, 1);
    sl_word = 8'($urandom);
    run_frame(8'($urandom), 2'd1, 2, sl_word, 1'b1, "cfg_mid");
    m_cpol = cfg_cpol;
    repeat (3) @(negedge clk);
    check("cfg_next sck_idle", 32'(bus.sck), 1);
    sl_word = 8'($urandom);
    run_frame(8'($urandom), 2'd1, 6, sl_word, 1'b0, "cfg_next");

    // Randomized frames.
    for (int k = 0; k < 8; k++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      sl_word = 8'($urandom);
      ridx = 2'($urandom_range(0, 3));
      run_frame(8'($urandom), ridx, int'(cfg_div) + 1,
                (int'(ridx) < NCS) ? sl_word : 8'h00, 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
